// File: rtl/se_pkg.sv
// rtl/se_pkg.sv - shared immediate/datapath widths and types
package se_pkg;

  localparam int IMM_W  = 12;
  localparam int WORD_W = 16;

  typedef logic [IMM_W-1:0]  imm_t;
  typedef logic [WORD_W-1:0] word_t;

endpackage

// File: rtl/se_12b_to_16b_sign_ext_cell.sv
// rtl/se_12b_to_16b_sign_ext_cell.sv - combinational sign-bit replicator IN_W -> OUT_W
module sign_ext_cell #(
  parameter int IN_W  = 12,
  parameter int OUT_W = 16
) (
  input  logic [IN_W-1:0]  in,
  output logic [OUT_W-1:0] out
);

  generate
    if (OUT_W < IN_W) begin : g_bad_width
      $error("sign_ext_cell: OUT_W must be >= IN_W");
    end else if (OUT_W == IN_W) begin : g_pass
      assign out = in;
    end else begin : g_ext
      // Zero-width replication is illegal, hence the equal-width branch above.
      assign out = {{(OUT_W-IN_W){in[IN_W-1]}}, in};
    end
  endgenerate

endmodule

// File: rtl/se_12b_to_16b.sv
// rtl/se_12b_to_16b.sv - immediate sign extension, combinational plus one registered stage
module se_12b_to_16b
  import se_pkg::*;
#(
  parameter int IN_W  = IMM_W,
  parameter int OUT_W = WORD_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IN_W-1:0]  in,
  input  logic             in_valid,
  output logic [OUT_W-1:0] out,
  output logic [OUT_W-1:0] out_q,
  output logic             out_valid,
  output logic             is_neg
);

  generate
    if (OUT_W < IN_W) begin : g_bad_width
      $error("se_12b_to_16b: OUT_W must be >= IN_W");
    end
  endgenerate

  sign_ext_cell #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) u_ext (
    .in  (in),
    .out (out)
  );

  assign is_neg = in[IN_W-1];

  // The register reuses the single extender output rather than a second copy.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_q     <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_q <= out;
      end
    end
  end

endmodule

// File: tb/tb_se_12b_to_16b.sv
// tb/tb_se_12b_to_16b.sv - self-checking bench for se_12b_to_16b
module tb_se_12b_to_16b;

  typedef struct packed {
    logic        valid;
    logic [15:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        clk_en = 1'b0;
  logic        rst_n;
  logic [11:0] in_r;
  logic        in_valid;
  logic [15:0] out;
  logic [15:0] out_q;
  logic        out_valid;
  logic        is_neg;

  int checks = 0;
  int errors = 0;

  exp_t        sb[$];
  logic [15:0] model_q;

  se_12b_to_16b dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in        (in_r),
    .in_valid  (in_valid),
    .out       (out),
    .out_q     (out_q),
    .out_valid (out_valid),
    .is_neg    (is_neg)
  );

  initial begin
    wait (clk_en);
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] sext(input logic [11:0] v);
    logic signed [15:0] s;
    s = $signed(v);
    return s;
  endfunction

  // One clock of registered-path stimulus: predict, clock, then compare.
  task automatic step(input logic rst, input logic v, input logic [11:0] d);
    exp_t e;
    exp_t got;
    rst_n    = rst;
    in_valid = v;
    in_r     = d;
    if (!rst) begin
      model_q = 16'h0000;
      e.valid = 1'b0;
    end else begin
      e.valid = v;
      if (v) model_q = sext(d);
    end
    e.data = model_q;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check("sb_underflow", 32'd1, 32'd0);
    end else begin
      got = sb.pop_front();
      check("out_valid", {31'd0, out_valid}, {31'd0, got.valid});
      check("out_q", {16'd0, out_q}, {16'd0, got.data});
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_r     = 12'h123;
    model_q  = 16'h0000;

    // Combinational checks with no clock and reset asserted.
    #10;
    check("pos_out", {16'd0, out}, 32'h0000_0123);
    check("pos_neg", {31'd0, is_neg}, 32'd0);
    check("pos_signed", 32'($signed(out)), 32'($signed(in_r)));
    in_r = 12'hFE1;
    #10;
    check("neg_out", {16'd0, out}, 32'h0000_FFE1);
    check("neg_neg", {31'd0, is_neg}, 32'd1);
    check("neg_signed", 32'($signed(out)), 32'hFFFF_FFE1);
    in_r = 12'h7FF; #1; check("bnd_7ff", {16'd0, out}, 32'h0000_07FF);
    in_r = 12'h800; #1; check("bnd_800", {16'd0, out}, 32'h0000_F800);
    in_r = 12'hFFF; #1; check("bnd_fff", {16'd0, out}, 32'h0000_FFFF);
    in_r = 12'h000; #1; check("bnd_000", {16'd0, out}, 32'h0000_0000);
    for (int i = 0; i < 4096; i++) begin
      in_r = 12'(i);
      #1;
      check("sweep", {16'd0, out}, {16'd0, sext(in_r)});
      check("sweep_neg", {31'd0, is_neg}, {31'd0, in_r[11]});
    end

    // Registered path.
    clk_en = 1'b1;
    step(1'b0, 1'b0, 12'h000);
    step(1'b0, 1'b0, 12'h000);
    step(1'b1, 1'b1, 12'hFE1);
    step(1'b1, 1'b0, 12'h123);
    step(1'b1, 1'b0, 12'h456);
    step(1'b1, 1'b1, 12'h7FF);
    step(1'b1, 1'b1, 12'h800);
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'($urandom_range(0, 1)), 12'($urandom_range(0, 4095)));
    end

    // Reset has priority over a valid input on the same edge.
    step(1'b1, 1'b1, 12'hABC);
    rst_n    = 1'b0;
    in_valid = 1'b1;
    in_r     = 12'h123;
    #1;
    check("rstpri_comb_pre", {16'd0, out}, 32'h0000_0123);
    step(1'b0, 1'b1, 12'h123);
    check("rstpri_comb_post", {16'd0, out}, 32'h0000_0123);
    step(1'b1, 1'b1, 12'h800);
    step(1'b1, 1'b0, 12'h000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
